// File: rtl/axis_pkg.sv
// Shared constants and types for the eight-axis snapshot scheduler.
// Fixed geometry: the byte-wide host address map only has room for 8 axes of 16 bits.
package axis_pkg;

    localparam int NAXIS  = 8;
    localparam int CW     = 16;
    localparam int IDX_W  = $clog2(NAXIS);

    // Address fields
    localparam int ADDR_W        = 5;
    localparam int ADDR_STAT     = 4;
    localparam int ADDR_AXIS_LSB = 1;
    localparam int ADDR_HI       = 0;

    // Status byte bit positions
    localparam int ST_VALID = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_PEND  = 3;
    localparam int ST_SEQ   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        CAP  = 2'd2,
        SWAP = 2'd3
    } state_e;

    function automatic logic [7:0] status_byte(
        input logic [3:0] seq,
        input logic       pend,
        input logic       busy,
        input logic       ovf,
        input logic       valid
    );
        logic [7:0] s;
        s              = '0;
        s[ST_SEQ +: 4] = seq;
        s[ST_PEND]     = pend;
        s[ST_BUSY]     = busy;
        s[ST_OVF]      = ovf;
        s[ST_VALID]    = valid;
        return s;
    endfunction

endpackage

// File: rtl/axis_snap_bank.sv
// Double-buffered NAXIS x CW shadow bank: captures go to the back bank,
// host reads come combinationally from the front bank, swap flips the roles.
module axis_snap_bank
    import axis_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CW-1:0]    wr_data,
    input  logic             swap,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_hi,
    output logic [7:0]       rd_byte
);

    logic [1:0][NAXIS-1:0][CW-1:0] bank_q, bank_d;
    logic                          front_q, front_d;
    logic [CW-1:0]                 rd_word;

    always_comb begin
        bank_d  = bank_q;
        front_d = front_q;
        if (wr_en) bank_d[~front_q][wr_idx] = wr_data;
        if (swap)  front_d = ~front_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q  <= '0;
            front_q <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            front_q <= front_d;
        end
    end

    assign rd_word = bank_q[front_q][rd_idx];
    assign rd_byte = rd_hi ? rd_word[CW-1 -: 8] : rd_word[7:0];

endmodule

// File: rtl/axis_lock_sched.sv
// Snapshot scheduler: lock pulse, eight-cycle capture into the back bank, swap.
// Optional free-running auto-lock timer enabled by defining AXIS_AUTOLOCK_EN.
module axis_lock_sched
    import axis_pkg::*;
#(
    parameter int PERIOD = 1000
) (
    input  logic                PClk,
    input  logic                nRst,
    input  logic                LockReq,
    input  logic [NAXIS*CW-1:0] PlsCnt,
    input  logic                RdReq,
    input  logic [ADDR_W-1:0]   Addr,
    output logic [NAXIS-1:0]    PosLock,
    output logic [7:0]          DQ,
    output logic                RdAck,
    output logic                Busy,
    output logic [3:0]          Seq
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [3:0]       seq_q, seq_d;
    logic [NAXIS-1:0] pos_lock_q, pos_lock_d;
    logic             busy_q, busy_d;
    logic [7:0]       dq_q, dq_d;
    logic             rd_ack_q, rd_ack_d;

    logic             req, auto_tick;
    logic             cap_we, swap, ovf_set, rd_stat;
    logic [CW-1:0]    cap_data;
    logic [7:0]       bank_byte;

`ifdef AXIS_AUTOLOCK_EN
    logic [15:0] tmr_q, tmr_d;

    always_comb begin
        auto_tick = (tmr_q == 16'(PERIOD - 1));
        tmr_d     = auto_tick ? 16'd0 : tmr_q + 16'd1;
    end

    always_ff @(posedge PClk or negedge nRst) begin
        if (!nRst) tmr_q <= '0;
        else       tmr_q <= tmr_d;
    end
`else
    logic [15:0] unused_period;
    assign unused_period = 16'(PERIOD);
    assign auto_tick     = 1'b0;
`endif

    assign req      = LockReq | auto_tick;
    assign cap_data = PlsCnt[idx_q*CW +: CW];

    axis_snap_bank u_bank (
        .clk     (PClk),
        .rst_n   (nRst),
        .wr_en   (cap_we),
        .wr_idx  (idx_q),
        .wr_data (cap_data),
        .swap    (swap),
        .rd_idx  (Addr[ADDR_AXIS_LSB +: IDX_W]),
        .rd_hi   (Addr[ADDR_HI]),
        .rd_byte (bank_byte)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        seq_d   = seq_q;
        cap_we  = 1'b0;
        swap    = 1'b0;
        ovf_set = 1'b0;

        case (state_q)
            IDLE: if (req || pend_q) state_d = LOCK;
            LOCK: begin
                pend_d  = req;
                idx_d   = '0;
                state_d = CAP;
            end
            CAP: begin
                cap_we = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NAXIS - 1)) state_d = SWAP;
            end
            SWAP: begin
                swap    = 1'b1;
                seq_d   = seq_q + 4'd1;
                valid_d = 1'b1;
                // Chain straight into the next lock to keep the 10-cycle minimum period.
                state_d = (req || pend_q) ? LOCK : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (req && (state_q == CAP || state_q == SWAP)) begin
            if (pend_q) ovf_set = 1'b1;
            else        pend_d  = 1'b1;
        end

        rd_stat = RdReq && Addr[ADDR_STAT];
        if (rd_stat) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;

        pos_lock_d = {NAXIS{state_d == LOCK}};
        busy_d     = (state_d != IDLE);
        rd_ack_d   = RdReq;
        dq_d       = dq_q;
        if (RdReq)
            dq_d = Addr[ADDR_STAT] ? status_byte(seq_q, pend_q, busy_q, ovf_q, valid_q)
                                   : bank_byte;
    end

    always_ff @(posedge PClk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            seq_q      <= '0;
            pos_lock_q <= '0;
            busy_q     <= 1'b0;
            dq_q       <= '0;
            rd_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            seq_q      <= seq_d;
            pos_lock_q <= pos_lock_d;
            busy_q     <= busy_d;
            dq_q       <= dq_d;
            rd_ack_q   <= rd_ack_d;
        end
    end

    assign PosLock = pos_lock_q;
    assign DQ      = dq_q;
    assign RdAck   = rd_ack_q;
    assign Busy    = busy_q;
    assign Seq     = seq_q;

endmodule

// File: tb/tb_axis_lock_sched.sv
// Bench for axis_lock_sched: phase-count reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axis_lock_sched;

    localparam int NAX = 8;
    localparam int PER = 16;

    logic             PClk    = 1'b0;
    logic             nRst    = 1'b0;
    logic             LockReq = 1'b0;
    logic             RdReq   = 1'b0;
    logic [NAX*16-1:0] PlsCnt = '0;
    logic [4:0]       Addr    = '0;
    logic [NAX-1:0]   PosLock;
    logic [7:0]       DQ;
    logic             RdAck;
    logic             Busy;
    logic [3:0]       Seq;

    int checks   = 0;
    int failures = 0;

    axis_lock_sched #(.PERIOD(PER)) dut (
        .PClk    (PClk),
        .nRst    (nRst),
        .LockReq (LockReq),
        .PlsCnt  (PlsCnt),
        .RdReq   (RdReq),
        .Addr    (Addr),
        .PosLock (PosLock),
        .DQ      (DQ),
        .RdAck   (RdAck),
        .Busy    (Busy),
        .Seq     (Seq)
    );

    always #5 PClk = ~PClk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_ph counts cycles since lock (0 idle, 1 lock,
    // 2..9 capture of axis m_ph-2, 10 swap); m_front is the visible snapshot.
    int          m_ph    = 0;
    logic        m_pend  = 1'b0;
    logic        m_ovf   = 1'b0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_seq   = '0;
    logic [7:0]  m_dq    = '0;
    logic        m_ack   = 1'b0;
    int          m_tmr   = 0;
    logic [15:0] m_front [NAX];
    logic [15:0] m_shot  [NAX];

    function automatic logic [7:0] m_read(input logic [4:0] a);
        logic [15:0] w;
        if (a[4]) return {m_seq, m_pend, (m_ph != 0), m_ovf, m_valid};
        w = m_front[a[3:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    always @(posedge PClk or negedge nRst) begin
        if (!nRst) begin
            m_ph <= 0; m_pend <= 1'b0; m_ovf <= 1'b0; m_valid <= 1'b0;
            m_seq <= '0; m_dq <= '0; m_ack <= 1'b0; m_tmr <= 0;
            for (int i = 0; i < NAX; i++) begin
                m_front[i] <= '0;
                m_shot[i]  <= '0;
            end
        end else begin
            logic rq, pnx, onx;
            rq = LockReq;
`ifdef AXIS_AUTOLOCK_EN
            rq = rq | (m_tmr == PER - 1);
            m_tmr <= (m_tmr + 1) % PER;
`endif
            m_ack <= RdReq;
            if (RdReq) m_dq <= m_read(Addr);
            pnx = m_pend;
            onx = m_ovf && !(RdReq && Addr[4]);
            if (m_ph >= 2 && rq) begin
                if (m_pend) onx = 1'b1;
                else        pnx = 1'b1;
            end
            if (m_ph == 1) pnx = rq;
            if (m_ph >= 2 && m_ph <= 9) m_shot[m_ph-2] <= PlsCnt[(m_ph-2)*16 +: 16];
            if (m_ph == 10) begin
                for (int i = 0; i < NAX; i++) m_front[i] <= m_shot[i];
                m_seq   <= m_seq + 4'd1;
                m_valid <= 1'b1;
            end
            if (m_ph == 0 || m_ph == 10) m_ph <= (rq || m_pend) ? 1 : 0;
            else                         m_ph <= m_ph + 1;
            m_pend <= pnx;
            m_ovf  <= onx;
        end
    end

    always @(negedge PClk) begin
        chk("PosLock", PosLock, (m_ph == 1) ? 8'hFF : 8'h00);
        chk("Busy",    Busy,    m_ph != 0);
        chk("Seq",     Seq,     m_seq);
        chk("RdAck",   RdAck,   m_ack);
        chk("DQ",      DQ,      m_dq);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PClk);
            #1;
        end
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
        Addr  = a;
        RdReq = 1'b1;
        step(1);
        RdReq = 1'b0;
        chk(nm, DQ, exp);
        chk({nm, "_ack"}, RdAck, 1'b1);
    endtask

    task automatic set_cnt(input logic [15:0] base);
        for (int i = 0; i < NAX; i++) PlsCnt[i*16 +: 16] = base + 16'(i);
    endtask

    task automatic lock_pulse();
        LockReq = 1'b1;
        step(1);
        LockReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        np = 0;
        nRst = 1'b0;
        step(3);
        chk("rst_poslock", PosLock, 8'h00);
        chk("rst_dq",      DQ,      8'h00);
        chk("rst_rdack",   RdAck,   1'b0);
        chk("rst_busy",    Busy,    1'b0);
        chk("rst_seq",     Seq,     4'd0);
        nRst = 1'b1;
`ifdef AXIS_AUTOLOCK_EN
        set_cnt(16'h3300);
        for (int k = 1; k <= 90; k++) begin
            LockReq = (k == 32);
            step(1);
            if (PosLock == 8'hFF) np++;
            if (k == 16) chk("auto_first", PosLock, 8'hFF);
        end
        LockReq = 1'b0;
        chk("auto_pulses", np, 5);
        chk("auto_seq", Seq, 4'd5);
        rd_chk("auto_hi7", 5'h0F, 8'h33);
`else
        set_cnt(16'h1100);
        step(3);

        // Single snapshot: ten busy cycles starting with the lock pulse.
        lock_pulse();
        chk("s1_poslock", PosLock, 8'hFF);
        chk("s1_busy0",   Busy,    1'b1);
        step(9);
        chk("s1_busy9",   Busy,    1'b1);
        chk("s1_seq_pre", Seq,     4'd0);
        step(1);
        chk("s1_idle",    Busy,    1'b0);
        chk("s1_seq",     Seq,     4'd1);
        rd_chk("s1_hi7",  5'h0F, 8'h11);
        rd_chk("s1_lo7",  5'h0E, 8'h07);
        rd_chk("s1_lo0",  5'h00, 8'h00);
        rd_chk("s1_stat", 5'h10, 8'h11);

        // Coherence: counts change in the first capture cycle; reads up to and
        // including the swap cycle still see the old snapshot.
        lock_pulse();
        step(1);
        set_cnt(16'h2200);
        for (int k = 0; k < 9; k++) rd_chk("coh_old", 5'h0F, 8'h11);
        rd_chk("coh_new7", 5'h0F, 8'h22);
        rd_chk("coh_new0", 5'h01, 8'h22);
        rd_chk("coh_lo3",  5'h06, 8'h03);

        // Pending then overflow during capture.
        lock_pulse();
        step(2);
        lock_pulse();
        step(1);
        lock_pulse();
        rd_chk("ovf_set", 5'h10, 8'h2F);
        rd_chk("ovf_clr", 5'h10, 8'h2D);
        step(2);
        chk("pend_swap_lock", PosLock, 8'h00);
        chk("pend_swap_busy", Busy,    1'b1);
        step(1);
        chk("pend_relock",    PosLock, 8'hFF);
        chk("pend_seq",       Seq,     4'd3);
        step(10);
        chk("pend_done_busy", Busy,    1'b0);
        chk("pend_done_seq",  Seq,     4'd4);

        // Seq wrap after sixteen snapshots.
        for (int k = 0; k < 12; k++) begin
            lock_pulse();
            step(10);
        end
        chk("wrap_seq", Seq, 4'd0);
        rd_chk("wrap_stat", 5'h10, 8'h01);
        rd_chk("wrap_hi7",  5'h0F, 8'h22);
        lock_pulse();
        step(10);
        chk("seq_after_wrap", Seq, 4'd1);

        // Reset asserted while capturing axis 3.
        lock_pulse();
        step(3);
        rd_chk("mid_cap_rd", 5'h0F, 8'h22);
        #2 nRst = 1'b0;
        #1;
        chk("mrst_poslock", PosLock, 8'h00);
        chk("mrst_dq",      DQ,      8'h00);
        chk("mrst_rdack",   RdAck,   1'b0);
        chk("mrst_busy",    Busy,    1'b0);
        chk("mrst_seq",     Seq,     4'd0);
        step(2);
        nRst = 1'b1;
        step(1);
        for (int a = 0; a < 16; a++) rd_chk("post_rst", 5'(a), 8'h00);
        rd_chk("post_rst_stat", 5'h10, 8'h00);
`endif
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
